// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES types and helpers: round-sequencer state encoding, AES-128 constants
// and the GF(2^8) doubling used by both the rcon generator and MixColumns.
package aes_package;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ROUND,
        ST_FINAL,
        ST_OUT
    } aes_round_state_t;

    localparam int         AES128_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT     = 8'h01;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] aes_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_ctrl_rcon_gen.sv
// Round-constant register: reloads RCON_INIT at block start and doubles in GF(2^8)
// every time a round key is expanded.
module aes_rcon_gen
    import aes_package::*;
(
    input  logic       clk,
    input  logic       i_clr,
    input  logic       i_init,
    input  logic       i_advance,
    output logic [7:0] o_rcon
);

    logic [7:0] r_rcon;

    always_ff @(posedge clk) begin
        if (i_clr || i_init) begin
            r_rcon <= RCON_INIT;
        end else if (i_advance) begin
            r_rcon <= aes_xtime(r_rcon);
        end
    end

    assign o_rcon = r_rcon;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES round datapath: initial AddRoundKey, the full
// rounds and the final (no MixColumns) round, framed by valid/ready handshakes.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | waiting for a block; load strobes fire on the input handshake
// ST_INIT  | one cycle of AddRoundKey with round key 0, first key expansion
// ST_ROUND | full rounds 1..NUM_ROUNDS-1, ROUND_LAT cycles each
// ST_FINAL | last round without MixColumns, ROUND_LAT cycles
// ST_OUT   | ciphertext held in the state register until out_ready
module aes_round_ctrl
    import aes_package::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int ROUND_LAT  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       dp_load,
    output logic       key_load,
    output logic       dp_init,
    output logic       dp_round_en,
    output logic       dp_skip_mix,
    output logic       key_exp_en,
    output logic [7:0] rcon,
    output logic [3:0] round_idx,
    output logic       busy,
    output logic       done
);

    localparam int CW = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;

    aes_round_state_t r_state;
    logic [CW-1:0]    r_wait;
    logic [3:0]       r_round_idx;

    logic       w_live;
    logic       w_run;
    logic       w_accept;
    logic       w_wait_last;
    logic       w_round_step;
    logic       w_key_exp;
    logic [7:0] w_rcon;

    assign w_live       = !reset;
    assign w_run        = !reset && !clear;
    assign w_accept     = w_run && (r_state == ST_IDLE) && in_valid;
    assign w_wait_last  = (r_wait == CW'(ROUND_LAT - 1));
    assign w_round_step = (r_state == ST_ROUND) && w_wait_last;
    assign w_key_exp    = w_run && ((r_state == ST_INIT) || w_round_step);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_state     <= ST_IDLE;
            r_wait      <= '0;
            r_round_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state     <= ST_INIT;
                        r_wait      <= '0;
                        r_round_idx <= '0;
                    end
                end
                ST_INIT: begin
                    r_state     <= ST_ROUND;
                    r_wait      <= '0;
                    r_round_idx <= 4'd1;
                end
                ST_ROUND: begin
                    if (w_wait_last) begin
                        r_wait      <= '0;
                        r_round_idx <= r_round_idx + 4'd1;
                        if (r_round_idx == 4'(NUM_ROUNDS - 1)) begin
                            r_state <= ST_FINAL;
                        end
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                ST_FINAL: begin
                    if (w_wait_last) begin
                        r_wait  <= '0;
                        r_state <= ST_OUT;
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_round_idx <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    aes_rcon_gen u_rcon_gen (
        .clk       (clk),
        .i_clr     (reset || clear),
        .i_init    (w_accept),
        .i_advance (w_key_exp),
        .o_rcon    (w_rcon)
    );

    // Datapath strobes are suppressed during an abort cycle; status follows state.
    assign in_ready    = w_run && (r_state == ST_IDLE);
    assign dp_load     = w_accept;
    assign key_load    = w_accept;
    assign dp_init     = w_run && (r_state == ST_INIT);
    assign dp_round_en = w_run && (w_round_step || ((r_state == ST_FINAL) && w_wait_last));
    assign dp_skip_mix = w_run && (r_state == ST_FINAL) && w_wait_last;
    assign key_exp_en  = w_key_exp;
    assign out_valid   = w_live && (r_state == ST_OUT);
    assign busy        = w_live && (r_state != ST_IDLE);
    assign done        = w_run && (r_state == ST_OUT) && out_ready;
    assign rcon        = w_live ? w_rcon : 8'h00;
    assign round_idx   = w_live ? r_round_idx : 4'd0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: three parameterisations driven by shared random stimulus,
// each checked every cycle against a block-timeline reference model.
module tb_aes_round_ctrl;

    localparam int         NI = 3;
    localparam int         P_NR [NI] = '{10, 10, 2};
    localparam int         P_L  [NI] = '{1, 3, 2};
    localparam logic [7:0] RCON_TAB [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                             8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    logic clk = 1'b0;
    logic reset, clear, in_valid, out_ready;

    logic [NI-1:0] in_ready, out_valid, dp_load, key_load, dp_init;
    logic [NI-1:0] dp_round_en, dp_skip_mix, key_exp_en, busy, done;
    logic [7:0]    rcon_o [NI];
    logic [3:0]    round_idx_o [NI];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bit m_busy  [NI];
    bit m_fresh [NI];
    int m_t0    [NI];

    always #5 clk = ~clk;

    aes_round_ctrl u_dut0 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .dp_load(dp_load[0]), .key_load(key_load[0]), .dp_init(dp_init[0]),
        .dp_round_en(dp_round_en[0]), .dp_skip_mix(dp_skip_mix[0]),
        .key_exp_en(key_exp_en[0]), .rcon(rcon_o[0]), .round_idx(round_idx_o[0]),
        .busy(busy[0]), .done(done[0])
    );

    aes_round_ctrl #(.NUM_ROUNDS(10), .ROUND_LAT(3)) u_dut1 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .dp_load(dp_load[1]), .key_load(key_load[1]), .dp_init(dp_init[1]),
        .dp_round_en(dp_round_en[1]), .dp_skip_mix(dp_skip_mix[1]),
        .key_exp_en(key_exp_en[1]), .rcon(rcon_o[1]), .round_idx(round_idx_o[1]),
        .busy(busy[1]), .done(done[1])
    );

    aes_round_ctrl #(.NUM_ROUNDS(2), .ROUND_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready[2]), .out_valid(out_valid[2]), .out_ready(out_ready),
        .dp_load(dp_load[2]), .key_load(key_load[2]), .dp_init(dp_init[2]),
        .dp_round_en(dp_round_en[2]), .dp_skip_mix(dp_skip_mix[2]),
        .key_exp_en(key_exp_en[2]), .rcon(rcon_o[2]), .round_idx(round_idx_o[2]),
        .busy(busy[2]), .done(done[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected outputs derived from the cycle offset since the accepting handshake.
    task automatic model_step(input int i);
        int nr, l, rel, tout, k;
        bit live, run, acc, rstep;
        bit e_ir, e_ov, e_busy, e_init, e_ren, e_skip, e_kexp, e_done;
        logic [3:0]  e_idx;
        logic [13:0] exp_v, got_v;
        nr = P_NR[i];
        l  = P_L[i];
        live = !reset;
        run  = !reset && !clear;
        e_ir = run && !m_busy[i];
        acc  = e_ir && in_valid;
        e_ov = 0; e_busy = 0; e_init = 0; e_ren = 0; e_skip = 0; e_kexp = 0; e_done = 0;
        e_idx = 4'd0;
        k = 0;
        if (live && m_busy[i]) begin
            rel    = cyc - m_t0[i];
            tout   = 2 + nr * l;
            e_busy = 1;
            e_ov   = rel >= tout;
            e_init = run && rel == 1;
            rstep  = rel >= 2 && rel < tout && ((rel - 1) % l) == 0;
            k      = (rel - 1) / l;
            e_ren  = run && rstep;
            e_skip = run && rstep && k == nr;
            e_kexp = run && (rel == 1 || (rstep && k < nr));
            e_idx  = (rel == 1) ? 4'd0 : (rel >= tout) ? 4'(nr) : 4'(1 + (rel - 2) / l);
            e_done = run && e_ov && out_ready;
            if (e_kexp)
                check_eq($sformatf("u%0d_c%0d_rcon", i, cyc), 32'(rcon_o[i]), 32'(RCON_TAB[k]));
        end else if (!live) begin
            check_eq($sformatf("u%0d_c%0d_rcon_rst", i, cyc), 32'(rcon_o[i]), 32'h0);
        end else if (m_fresh[i]) begin
            check_eq($sformatf("u%0d_c%0d_rcon_idle", i, cyc), 32'(rcon_o[i]), 32'h01);
        end
        exp_v = {e_ir, e_ov, e_busy, acc, acc, e_init, e_ren, e_skip, e_kexp, e_done, e_idx};
        got_v = {in_ready[i], out_valid[i], busy[i], dp_load[i], key_load[i], dp_init[i],
                 dp_round_en[i], dp_skip_mix[i], key_exp_en[i], done[i], round_idx_o[i]};
        check_eq($sformatf("u%0d_c%0d_outs", i, cyc), 32'(got_v), 32'(exp_v));
        if (!run) begin
            m_busy[i]  = 0;
            m_fresh[i] = 1;
        end else if (acc) begin
            m_busy[i]  = 1;
            m_t0[i]    = cyc;
            m_fresh[i] = 0;
        end else if (e_done) begin
            m_busy[i]  = 0;
            m_fresh[i] = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NI; i++) model_step(i);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_out_valid0(input string tag);
        for (int n = 0; n < 80 && !out_valid[0]; n++) tick();
        check_eq(tag, 32'(out_valid[0]), 32'h1);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_busy[i]  = 0;
            m_fresh[i] = 1;
            m_t0[i]    = 0;
        end
        reset = 1; clear = 0; in_valid = 1; out_ready = 0;
        repeat (4) tick();

        // single block, output side always ready
        reset = 0; out_ready = 1;
        tick();
        in_valid = 0;
        repeat (40) tick();

        // backpressure on the output handshake
        in_valid = 1;
        tick();
        in_valid = 0; out_ready = 0;
        wait_out_valid0("wait_bp_out_valid");
        repeat (5) tick();
        out_ready = 1;
        repeat (35) tick();

        // abort six cycles after accept, then a fresh block two cycles later
        in_valid = 1;
        tick();
        in_valid = 0;
        repeat (5) tick();
        clear = 1;
        tick();
        clear = 0;
        tick();
        in_valid = 1;
        tick();
        in_valid = 0;
        repeat (40) tick();

        // reset while holding a finished block, with in_valid high throughout
        in_valid = 1;
        tick();
        in_valid = 0; out_ready = 0;
        wait_out_valid0("wait_rst_out_valid");
        reset = 1; in_valid = 1;
        repeat (3) tick();
        reset = 0; in_valid = 0; out_ready = 1;
        repeat (5) tick();

        repeat (3000) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 59) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 0; clear = 0; in_valid = 0; out_ready = 1;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
